// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one async-FIFO write port among N requesters.
// Grants are registered; ack/wr_rq/wdata are combinational so full is never stale.
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int BURST = 4
) (
    input  logic               w_clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] din,
    input  logic               full,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       ack,
    output logic               wr_rq,
    output logic [WIDTH-1:0]   wdata
);
    localparam int LW = $clog2(N);
    typedef enum logic {IDLE, OWN} state_t;
    state_t        r_state, w_state;
    logic [LW-1:0] r_owner, w_owner, r_ptr, w_ptr, w_start, w_win, w_next_ptr;
    logic [7:0]    r_bcnt, w_bcnt;
    logic [N-1:0]  r_gnt, w_gnt, w_cand;
    logic          w_found, w_rel;

    assign gnt        = r_gnt;
    assign ack        = r_gnt & req & {N{~full}};
    assign wr_rq      = |ack;
    assign wdata      = (|r_gnt) ? din[int'(r_owner)*WIDTH +: WIDTH] : '0;
    assign w_next_ptr = (r_owner == LW'(N - 1)) ? '0 : r_owner + 1'b1;
    assign w_start    = (r_state == IDLE) ? r_ptr : w_next_ptr;
    assign w_cand     = (r_state == IDLE) ? req : req & ~(N'(1) << r_owner);
    assign w_rel      = (r_state == OWN) &&
                        (!req[r_owner] || (ack[r_owner] && int'(r_bcnt) + 1 == BURST));

    // Scan downward so the lowest offset from w_start is the final winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_cand[(int'(w_start) + k) % N]) begin
                w_found = 1'b1;
                w_win   = LW'((int'(w_start) + k) % N);
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_owner = r_owner;
        w_ptr   = r_ptr;
        w_bcnt  = r_bcnt;
        w_gnt   = r_gnt;
        if (r_state == IDLE || w_rel) begin
            if (w_rel)
                w_ptr = w_next_ptr;
            if (w_found) begin
                w_state = OWN;
                w_owner = w_win;
                w_bcnt  = '0;
                w_gnt   = N'(1) << w_win;
            end else if (w_rel && req[r_owner]) begin
                w_bcnt  = '0;
            end else begin
                w_state = IDLE;
                w_gnt   = '0;
            end
        end else if (ack[r_owner]) begin
            w_bcnt = r_bcnt + 1'b1;
        end
    end

    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_bcnt  <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state;
            r_owner <= w_owner;
            r_ptr   <= w_ptr;
            r_bcnt  <= w_bcnt;
            r_gnt   <= w_gnt;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random checks of fifo_wr_arbiter against a behavioural model.
module tb_fifo_wr_arbiter;
    localparam int WIDTH = 8, N = 4, BURST = 4, D = 2048;
    logic               w_clk = 1'b0, rst = 1'b0, full;
    logic [N-1:0]       req, gnt, ack;
    logic [N*WIDTH-1:0] din;
    logic               wr_rq;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH-1:0]   src [N][D];
    int                 idx [N];
    int                 m_idx [N];
    int                 m_owner = -1, m_ptr = 0, m_bcnt = 0;
    logic [N-1:0]       last_ack = '0;
    int                 log_q [$];
    int                 n_pass = 0, n_total = 0;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .N(N), .BURST(BURST)) dut (
        .w_clk(w_clk), .rst(rst), .req(req), .din(din), .full(full),
        .gnt(gnt), .ack(ack), .wr_rq(wr_rq), .wdata(wdata)
    );

    always #5 w_clk = ~w_clk;

    always_comb
        for (int i = 0; i < N; i++) din[i*WIDTH +: WIDTH] = src[i][idx[i] % D];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input int start, input logic [N-1:0] r, input int excl);
        for (int k = 0; k < N; k++)
            if (r[(start + k) % N] && (start + k) % N != excl) return (start + k) % N;
        return -1;
    endfunction

    // Reference: owner/ptr/count kept as plain integers, words indexed per requester.
    always @(negedge w_clk) begin
        logic [N-1:0] eg, ea;
        int ew, w, id;
        bit acc, rel;
        if (rst) begin
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_ack", int'(ack), 0);
            chk("rst_wr_rq", int'(wr_rq), 0);
            chk("rst_wdata", int'(wdata), 0);
            m_owner = -1;
            m_ptr = 0;
            m_bcnt = 0;
            last_ack = '0;
        end else begin
            eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
            ea = eg & req & {N{~full}};
            ew = 0;
            if (m_owner >= 0) ew = int'(src[m_owner][m_idx[m_owner] % D]);
            chk("gnt", int'(gnt), int'(eg));
            chk("ack", int'(ack), int'(ea));
            chk("wr_rq", int'(wr_rq), int'(|ea));
            chk("wdata", int'(wdata), ew);
            chk("onehot", int'($onehot0(gnt)), 1);
            if (wr_rq) begin
                id = 0;
                for (int i = 0; i < N; i++) if (ack[i]) id = i;
                log_q.push_back((id << 8) | int'(wdata));
            end
            last_ack = ack;
            acc = (m_owner >= 0) && ea[m_owner];
            if (acc) m_idx[m_owner]++;
            if (m_owner < 0) begin
                w = pick(m_ptr, req, -1);
                if (w >= 0) begin m_owner = w; m_bcnt = 0; end
            end else begin
                rel = !req[m_owner] || (acc && m_bcnt + 1 == BURST);
                if (rel) begin
                    m_ptr = (m_owner + 1) % N;
                    w = pick(m_ptr, req, m_owner);
                    if (w >= 0) begin m_owner = w; m_bcnt = 0; end
                    else if (req[m_owner]) m_bcnt = 0;
                    else m_owner = -1;
                end else if (acc) m_bcnt++;
            end
        end
    end

    task automatic tick;
        @(posedge w_clk);
        #1;
        for (int i = 0; i < N; i++) if (last_ack[i]) idx[i]++;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cyc, bad, n2;
        req = '0;
        full = 1'b0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < D; k++) src[i][k] = WIDTH'($urandom);
        for (int k = 0; k < 6; k++) src[0][k] = WIDTH'(8'h11 + k);
        #1;
        // Single requester, 6 words through a 4-word burst
        do_reset();
        log_q.delete();
        req = 4'b0001;
        tick();
        #3 chk("t1_grant", int'(gnt), 1);
        cyc = 0;
        while (idx[0] < 6 && cyc < 20) begin tick(); cyc++; end
        chk("t1_cycles", cyc, 6);
        req = '0;
        chk("t1_count", log_q.size(), 6);
        for (int k = 0; k < 6 && k < log_q.size(); k++) chk("t1_word", log_q[k], 8'h11 + k);
        tick();
        tick();
        // All requesting: 0,1,2,3,0 x4 words with no gaps
        do_reset();
        log_q.delete();
        req = 4'b1111;
        repeat (21) tick();
        chk("t2_count", log_q.size(), 20);
        bad = 0;
        for (int j = 0; j < 20 && j < log_q.size(); j++) if ((log_q[j] >> 8) != (j / 4) % 4) bad++;
        chk("t2_order", bad, 0);
        // Full stalls owner 2 after two words
        do_reset();
        log_q.delete();
        req = 4'b0100;
        repeat (3) tick();
        full = 1'b1;
        req = 4'b0110;
        repeat (5) begin
            #3;
            chk("t3_hold_gnt", int'(gnt), 4);
            chk("t3_no_wr", int'(wr_rq), 0);
            tick();
        end
        full = 1'b0;
        tick();
        tick();
        #3 chk("t3_handoff", int'(gnt), 2);
        n2 = 0;
        foreach (log_q[j]) if ((log_q[j] >> 8) == 2) n2++;
        chk("t3_words", n2, 4);
        // Owner 1 drops after one word; 3 must beat 0
        do_reset();
        req = 4'b1010;
        tick();
        #3 chk("t4_first", int'(gnt), 2);
        tick();
        req = 4'b1001;
        tick();
        #3 chk("t4_next", int'(gnt), 8);
        // Reset mid-burst
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_gnt", int'(gnt), 0);
        chk("t5_rst_wr", int'(wr_rq), 0);
        tick();
        rst = 1'b0;
        req = 4'b0011;
        tick();
        #3 chk("t5_regrant", int'(gnt), 1);
        // Random traffic
        do_reset();
        repeat (1000) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            full = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of the async FIFO among N requesters in the write clock domain. Each requester gets the port for a burst of up to BURST words, and the arbiter drives the FIFO's `wr_rq`/`wdata` directly. The arbiter respects `full`, so no word is ever offered while the FIFO cannot take it. It sits between the write-side producers and the FIFO's write interface.

## Interface
- `WIDTH`, 8: data word width; must match the FIFO `WIDTH`.
- `N`, 4: number of requesters (2..8).
- `BURST`, 4: maximum accepted words per grant (1..255).

- `w_clk`  in  1  write-domain clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N  per-requester write request; held high while data is valid.
- `din`  in  N*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- `full`  in  1  FIFO full flag, already synchronous to `w_clk`.
- `gnt`  out  N  registered one-hot grant; all zero when idle.
- `ack`  out  N  combinational; `ack[i] = gnt[i] & req[i] & ~full`. The word is consumed at this edge.
- `wr_rq`  out  1  combinational; equals `|ack`.
- `wdata`  out  WIDTH  combinational; the `din` slice of the granted requester, zero when `gnt == 0`.

## Operation
- State: IDLE or OWN; `owner` index; `ptr` (next-priority index, log2 N bits); `bcnt` (8 bits).
- IDLE:
  - If `|req`, at the next edge grant the first requesting index scanning ptr, ptr+1, …, wrapping modulo N.
  - Move to OWN and clear `bcnt` to 0.
  - If `req == 0`, stay in IDLE.
- OWN, per edge:
  - Accepted word (`ack[owner]`): `bcnt` increments.
  - Release condition 1: `req[owner]` is 0.
  - Release condition 2: an accepted word makes `bcnt + 1 == BURST`.
  - On release: `ptr` becomes owner+1 mod N. At the same edge, re-arbitrate from the new `ptr` over the current `req` with the owner excluded.
  - If another requester wins, the new grant is registered at that edge, giving back-to-back grants with no idle cycle. `bcnt` clears to 0.
  - If no other requester is active but the owner still requests (burst exhausted), the owner is re-granted with `bcnt` = 0.
  - Otherwise go to IDLE with `gnt = 0`.
- `full` high while in OWN:
  - No ack and no `wr_rq`.
  - `bcnt` holds and the grant is held. A full FIFO never causes release.
  - Release by `req` deassertion still applies.
- Requesters must hold `din` stable while `req` is high and no ack has occurred. A requester may drop `req` at any time; no word is lost, because only acked words are written.
- Fairness: with all N requesting continuously and the FIFO never full, each requester gets exactly BURST words per round in index order from `ptr`.

## Timing
- Reset values:
  - `gnt` = 0, `ack` = 0, `wr_rq` = 0, `wdata` = 0.
  - `ptr` = 0, `bcnt` = 0, state IDLE.
- Arbitration latency: `req` rising in IDLE gives `gnt` high after 1 edge. The first ack can occur in the cycle after that edge.
- Throughput: 1 word per `w_clk` cycle while the owner requests and `full` is 0. This holds across owner handoffs too.
- Write timing: the FIFO samples `wr_rq`/`wdata` on the same edge at which `ack` is seen. This is a zero-latency combinational path, so `full` is never stale.
- `rst` mid-burst:
  - `gnt` clears asynchronously, so `wr_rq` drops immediately.
  - The word not yet acked is not written.
  - `ptr` returns to 0.
- Simultaneous events:
  - Release and a new `req` at the same edge: the new `req` takes part in the re-arbitration.
  - `full` rising in the same cycle as the final burst word: no ack, so `bcnt` does not complete and there is no release.

## Test plan
- Reset, then `req = 4'b0001`, `din[0]` = 0x11..0x16 (6 words), BURST = 4. Expected:
  - `gnt` = 0001 one cycle after `req`.
  - 4 acks, then 1 cycle re-grant (no other requester), then 2 more acks.
  - FIFO receives 0x11..0x16 in order.
- `req = 4'b1111` continuous, `full` = 0, `ptr` = 0. Expected:
  - Grant order 0,1,2,3,0, each holding exactly 4 acks.
  - No idle cycle between owners.
  - `wr_rq` high every cycle after the first grant.
- Owner 2 streaming; `full` = 1 for 5 cycles after its 2nd word. Expected:
  - `wr_rq` = 0 for those 5 cycles and `gnt` stays 0100.
  - After `full` drops, exactly 2 more words are accepted, then release.
- Owner 1 drops `req` after 1 word while `req[3]` is high. Expected:
  - `gnt` = 1000 at the next edge and `ptr` = 2.
  - Requester 3 is served before 0.
- `rst` pulsed while owner 0 is mid-burst. Expected:
  - `gnt`, `wr_rq` = 0 immediately.
  - After release with `req = 4'b0011`, the first grant goes to requester 0.
- Scoreboard: push on every `wr_rq & ~full` edge, pop and compare on FIFO reads. Run 1000 random cycles with random `req` and `full` and confirm no mismatch, no overflow, and `gnt` always one-hot or zero.
